// File: rtl/cofi_multitap_pkg.sv
// Shared definitions for the multi-tap horizontal colour blender: mode encoding,
// line-start run counter width and its update rule.
package cofi_multitap_pkg;

  typedef enum logic [1:0] {
    COFI_BYPASS   = 2'd0,
    COFI_2TAP     = 2'd1,
    COFI_3TAP     = 2'd2,
    COFI_2TAP_ALT = 2'd3
  } cofi_mode_e;

  localparam int unsigned RUN_W = 2;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(2);

  // Active pixels since blank ended, saturating once a full 3-tap history exists
  function automatic logic [RUN_W-1:0] run_next(input logic [RUN_W-1:0] run, input logic clr);
    if (clr) return '0;
    if (run == RUN_MAX) return run;
    return run + RUN_W'(1);
  endfunction

endpackage

// File: rtl/cofi_multitap_if.sv
// Video stream bundle between the video generator (master) and the blender (slave).
interface cofi_multitap_if #(
  parameter int unsigned VIDEO_DEPTH = 8,
  parameter int unsigned CHANNELS    = 3
);
  localparam int unsigned RGB_W = VIDEO_DEPTH * CHANNELS;

  logic             pix_ce;
  logic [1:0]       mode;
  logic             hblank_in;
  logic             vblank_in;
  logic             hs_in;
  logic             vs_in;
  logic [RGB_W-1:0] rgb_in;
  logic             hblank_out;
  logic             vblank_out;
  logic             hs_out;
  logic             vs_out;
  logic [RGB_W-1:0] rgb_out;
  logic [1:0]       mode_active;

  modport master (
    output pix_ce, mode, hblank_in, vblank_in, hs_in, vs_in, rgb_in,
    input  hblank_out, vblank_out, hs_out, vs_out, rgb_out, mode_active
  );

  modport slave (
    input  pix_ce, mode, hblank_in, vblank_in, hs_in, vs_in, rgb_in,
    output hblank_out, vblank_out, hs_out, vs_out, rgb_out, mode_active
  );
endinterface

// File: rtl/cofi_multitap_tap_channel.sv
// One colour channel: two-pixel history and the rounded 1/2/3-tap blend.
// blend_c is combinational; the top registers it together with the syncs.
module cofi_multitap_tap_channel
  import cofi_multitap_pkg::*;
#(
  parameter int unsigned VIDEO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic [RUN_W-1:0]       run,
  input  cofi_mode_e             mode_active,
  input  logic [VIDEO_DEPTH-1:0] c,
  output logic [VIDEO_DEPTH-1:0] blend_c
);
  localparam int unsigned W1 = VIDEO_DEPTH + 1;
  localparam int unsigned W2 = VIDEO_DEPTH + 2;

  logic [VIDEO_DEPTH-1:0] p1_q, p2_q;
  logic [VIDEO_DEPTH-1:0] p1_e, p2_e;
  logic [W1-1:0]          sum2;
  logic [W2-1:0]          sum3;

  // History shifts on every ce, blank included; edge replicate masks it at line start
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_q <= '0;
      p2_q <= '0;
    end else if (ce) begin
      p1_q <= c;
      p2_q <= p1_q;
    end
  end

  always_comb begin
    p1_e = p1_q;
    p2_e = p2_q;
    if (run == '0) begin
      p1_e = c;
      p2_e = c;
    end else if (run == RUN_W'(1)) begin
      p2_e = p1_q;
    end
  end

  assign sum2 = W1'(p1_e) + W1'(c) + W1'(1);
  assign sum3 = W2'(p2_e) + W2'({p1_e, 1'b0}) + W2'(c) + W2'(2);

  always_comb begin
    blend_c = c;
    case (mode_active)
      COFI_BYPASS: blend_c = c;
      COFI_3TAP:   blend_c = sum3[W2-1:2];
      default:     blend_c = sum2[W1-1:1];
    endcase
  end

endmodule

// File: rtl/cofi_multitap.sv
// Horizontal colour blender: 1-ce sync delay, vblank-aligned mode latch,
// line-start run counter, per-channel tap filters and optional blank zeroing.
module cofi_multitap
  import cofi_multitap_pkg::*;
#(
  parameter int unsigned VIDEO_DEPTH = 8,
  parameter int unsigned CHANNELS    = 3,
  parameter bit          BLANK_ZERO  = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  cofi_multitap_if.slave vid
);
  localparam int unsigned RGB_W = VIDEO_DEPTH * CHANNELS;

  logic [RUN_W-1:0] run_q;
  cofi_mode_e       mode_q;
  logic [RGB_W-1:0] blend_c;
  logic             blank_c;
  logic             vbl_rise_c;

  assign blank_c    = vid.hblank_in | vid.vblank_in;
  assign vbl_rise_c = vid.vblank_in & ~vid.vblank_out;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    cofi_multitap_tap_channel #(
      .VIDEO_DEPTH(VIDEO_DEPTH)
    ) u_tap (
      .clk         (clk),
      .reset       (reset),
      .ce          (vid.pix_ce),
      .run         (run_q),
      .mode_active (mode_q),
      .c           (vid.rgb_in[g*VIDEO_DEPTH +: VIDEO_DEPTH]),
      .blend_c     (blend_c[g*VIDEO_DEPTH +: VIDEO_DEPTH])
    );
  end

  // Mode only moves on the first vblank ce of a frame so a frame is never split
  always_ff @(posedge clk) begin
    if (reset) begin
      vid.hblank_out <= 1'b0;
      vid.vblank_out <= 1'b0;
      vid.hs_out     <= 1'b0;
      vid.vs_out     <= 1'b0;
      vid.rgb_out    <= '0;
      run_q          <= '0;
      mode_q         <= COFI_BYPASS;
    end else if (vid.pix_ce) begin
      vid.hblank_out <= vid.hblank_in;
      vid.vblank_out <= vid.vblank_in;
      vid.hs_out     <= vid.hs_in;
      vid.vs_out     <= vid.vs_in;
      vid.rgb_out    <= (BLANK_ZERO && blank_c) ? '0 : blend_c;
      run_q          <= run_next(run_q, blank_c);
      if (vbl_rise_c) mode_q <= cofi_mode_e'(vid.mode);
    end
  end

  assign vid.mode_active = mode_q;

endmodule

// File: tb/tb_cofi_multitap.sv
// Directed bench for cofi_multitap: the driver queues hand-computed expectations,
// the monitor pops on every ce/reset edge and otherwise checks that outputs hold.
module tb_cofi_multitap;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hb;
    logic        vb;
    logic        hs;
    logic        vs;
    logic [1:0]  mode;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mon_en = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t last = '0;

  cofi_multitap_if #(.VIDEO_DEPTH(8), .CHANNELS(3)) vid ();

  cofi_multitap #(
    .VIDEO_DEPTH (8),
    .CHANNELS    (3),
    .BLANK_ZERO  (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vid   (vid)
  );

  always #5 clk = ~clk;

  task automatic compare(input exp_t e, input string tag);
    checks++;
    if (vid.rgb_out !== e.rgb) begin
      errors++;
      $display("FAIL %s rgb_out t=%0t got=%06h want=%06h", tag, $time, vid.rgb_out, e.rgb);
    end
    checks++;
    if ({vid.hblank_out, vid.vblank_out, vid.hs_out, vid.vs_out} !== {e.hb, e.vb, e.hs, e.vs}) begin
      errors++;
      $display("FAIL %s syncs(hb,vb,hs,vs) t=%0t got=%04b want=%04b", tag, $time,
               {vid.hblank_out, vid.vblank_out, vid.hs_out, vid.vs_out}, {e.hb, e.vb, e.hs, e.vs});
    end
    checks++;
    if (vid.mode_active !== e.mode) begin
      errors++;
      $display("FAIL %s mode_active t=%0t got=%0d want=%0d", tag, $time, vid.mode_active, e.mode);
    end
  endtask

  // Monitor: a ce or reset edge presents a new output; other edges must hold
  always @(posedge clk) begin
    logic v;
    exp_t e;
    v = vid.pix_ce | reset;
    #1;
    if (mon_en) begin
      if (v) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty t=%0t got=output want=expectation", $time);
        end else begin
          e = sb.pop_front();
          last = e;
          compare(e, "pix");
        end
      end else begin
        compare(last, "hold");
      end
    end
  end

  task automatic step(input logic rst, ce, hb, vb, hs, vs, input logic [1:0] md,
                      input logic [23:0] rgb, exp_rgb, input logic [1:0] exp_mode);
    exp_t e;
    @(negedge clk);
    mon_en        = 1'b1;
    reset         = rst;
    vid.pix_ce    = ce;
    vid.hblank_in = hb;
    vid.vblank_in = vb;
    vid.hs_in     = hs;
    vid.vs_in     = vs;
    vid.mode      = md;
    vid.rgb_in    = rgb;
    if (rst) begin
      e = '0;
      sb.push_back(e);
    end else if (ce) begin
      e.rgb  = exp_rgb;
      e.hb   = hb;
      e.vb   = vb;
      e.hs   = hs;
      e.vs   = vs;
      e.mode = exp_mode;
      sb.push_back(e);
    end
  endtask

  initial begin
    vid.pix_ce    = 1'b0;
    vid.mode      = 2'd0;
    vid.hblank_in = 1'b0;
    vid.vblank_in = 1'b0;
    vid.hs_in     = 1'b0;
    vid.vs_in     = 1'b0;
    vid.rgb_in    = '0;

    // Reset with random inputs: everything zero, bypass
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           2'($urandom), 24'($urandom), 24'h000000, 2'd0);

    // Bypass; mode request mid-frame is ignored
    step(0, 1, 0, 0, 0, 0, 2'd2, 24'h123456, 24'h123456, 2'd0);
    step(0, 1, 0, 0, 1, 0, 2'd2, 24'hABCDEF, 24'hABCDEF, 2'd0);
    step(0, 1, 0, 0, 0, 0, 2'd2, 24'h00FF80, 24'h00FF80, 2'd0);

    // vblank rise latches 3-tap; held vblank does not relatch
    step(0, 1, 1, 1, 0, 1, 2'd2, 24'h777777, 24'h000000, 2'd2);
    step(0, 1, 1, 1, 0, 1, 2'd0, 24'h777777, 24'h000000, 2'd2);
    step(0, 1, 1, 0, 1, 0, 2'd0, 24'h555555, 24'h000000, 2'd2);

    // 3-tap line with edge replicate
    step(0, 1, 0, 0, 0, 0, 2'd0, 24'h003340, 24'h003340, 2'd2);
    step(0, 1, 0, 0, 0, 0, 2'd0, 24'h003380, 24'h003350, 2'd2);
    step(0, 1, 0, 0, 0, 0, 2'd0, 24'h0033C0, 24'h003380, 2'd2);
    step(0, 1, 0, 0, 0, 0, 2'd0, 24'h0033C0, 24'h0033B0, 2'd2);

    // Switch to 2-tap at next vblank rise
    step(0, 1, 1, 0, 0, 0, 2'd1, 24'h111111, 24'h000000, 2'd2);
    step(0, 1, 1, 1, 0, 1, 2'd1, 24'h111111, 24'h000000, 2'd1);
    step(0, 1, 1, 0, 0, 0, 2'd1, 24'h111111, 24'h000000, 2'd1);

    // 2-tap line: 0x00 then 0xFF on ch0, ramp on ch1, flat ch2
    step(0, 1, 0, 0, 0, 0, 2'd1, 24'h201000, 24'h201000, 2'd1);
    step(0, 1, 0, 0, 0, 0, 2'd1, 24'h203000, 24'h202000, 2'd1);
    step(0, 1, 0, 0, 0, 0, 2'd1, 24'h2030FF, 24'h203080, 2'd1);
    step(0, 1, 0, 0, 0, 0, 2'd1, 24'h2030FF, 24'h2030FF, 2'd1);

    // pix_ce 1,0,0,1: nothing moves on the idle cycles
    step(0, 1, 0, 0, 1, 1, 2'd1, 24'h203001, 24'h203080, 2'd1);
    step(0, 0, 1, 1, 0, 0, 2'd3, 24'h999999, 24'h000000, 2'd1);
    step(0, 0, 1, 1, 0, 0, 2'd3, 24'h999999, 24'h000000, 2'd1);
    step(0, 1, 0, 0, 0, 0, 2'd1, 24'h203003, 24'h203002, 2'd1);

    // All-ones in 3-tap: no wrap at edge, zero during hblank
    step(0, 1, 1, 1, 0, 1, 2'd2, 24'hFFFFFF, 24'h000000, 2'd2);
    step(0, 1, 1, 0, 0, 0, 2'd2, 24'hFFFFFF, 24'h000000, 2'd2);
    step(0, 1, 0, 0, 0, 0, 2'd2, 24'hFFFFFF, 24'hFFFFFF, 2'd2);
    step(0, 1, 0, 0, 0, 0, 2'd2, 24'hFFFFFF, 24'hFFFFFF, 2'd2);
    step(0, 1, 0, 0, 0, 0, 2'd2, 24'hFFFFFF, 24'hFFFFFF, 2'd2);
    step(0, 1, 1, 0, 1, 0, 2'd2, 24'hFFFFFF, 24'h000000, 2'd2);
    step(0, 1, 0, 0, 0, 0, 2'd2, 24'hFFFFFF, 24'hFFFFFF, 2'd2);

    // Reset coinciding with a vblank rise wins
    step(1, 1, 0, 1, 1, 1, 2'd1, 24'h445566, 24'h000000, 2'd0);
    step(0, 1, 0, 0, 0, 0, 2'd1, 24'h102030, 24'h102030, 2'd0);

    step(0, 0, 0, 0, 0, 0, 2'd0, 24'h000000, 24'h000000, 2'd0);
    step(0, 0, 0, 0, 0, 0, 2'd0, 24'h000000, 24'h000000, 2'd0);
    @(negedge clk);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d pending want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
